// File: rtl/prio_arbiter.sv
// prio_arbiter
// Registered N-channel arbiter placed between N bus masters and the shared
// resource mux. It grants one requester per decision and keeps that grant
// until the owner drops its request. Selection is either fixed priority, with
// the highest channel index winning, or round-robin, chosen at runtime. An
// optional hold limit lets another waiting channel take over from an owner.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   req      - [N-1:0] level request lines, bit k = channel k
//   rr_en    - 0 = fixed priority, 1 = round-robin (sampled at decisions)
//   gnt      - [N-1:0] one-hot registered grant, zero when no owner
//   gnt_idx  - [IDXW-1:0] binary index of the owner, zero when no owner
//   gnt_vld  - high while a grant is held
//   idle     - high while there is no owner
module prio_arbiter #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            rr_en,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            idle
);

    localparam int SELW  = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int LIMIT = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [N-1:0]    cand;
    logic            ownerReq;
    logic            atLimit;
    logic [SELW-1:0] winFixed;
    logic [SELW-1:0] winRr;
    logic [SELW-1:0] winSel;
    logic [SELW-1:0] pos;

    // The owner is masked out of the candidate set. This gives the preemption
    // mask directly. When the owner has released, its req bit is already zero,
    // and in IDLE gnt_q is zero, so a single candidate set serves every case.
    assign cand     = req & ~gnt_q;
    assign ownerReq = |(req & gnt_q);
    assign atLimit  = (MAX_HOLD > 0) && (cnt_q == CNTW'(LIMIT));

    // Winner search. The fixed-priority loop lets the highest set index
    // overwrite earlier hits. The round-robin loop walks downward from
    // distance N to distance 1 above last_q, so the nearest set bit above
    // last_q is written last and wins. last_q itself is tried last.
    always_comb begin
        winFixed = '0;
        winRr    = '0;
        pos      = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                winFixed = SELW'(i);
            end
        end
        for (int k = N; k >= 1; k--) begin
            pos = SELW'((int'(last_q) + k) % N);
            if (cand[pos]) begin
                winRr = pos;
            end
        end
        winSel = rr_en ? winRr : winFixed;
    end

    // Next-state logic. A new grant is issued when leaving IDLE, on a release
    // that has other requesters waiting (with no bubble), and on a preemption.
    // At the hold limit with nobody waiting, only the counter restarts.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if ((state_q == ST_IDLE && |req) ||
            (state_q == ST_GRANT && !ownerReq && |cand) ||
            (state_q == ST_GRANT && ownerReq && atLimit && |cand)) begin
            state_d        = ST_GRANT;
            gnt_d          = '0;
            gnt_d[winSel]  = 1'b1;
            idx_d          = IDXW'(winSel);
            last_d         = IDXW'(winSel);
            cnt_d          = '0;
        end else if (state_q == ST_GRANT && !ownerReq) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (state_q == ST_GRANT && atLimit) begin
            cnt_d = '0;
        end else if (state_q == ST_GRANT && MAX_HOLD > 0) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // State registers. last_q resets to N-1 so that the first round-robin
    // search starts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IDXW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = |gnt_q;
    assign idle    = ~|gnt_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter
// Self-checking bench for prio_arbiter. The main instance uses N=8, IDXW=3
// and MAX_HOLD=4. It runs a table of {req, rr_en, expected grant} vectors,
// and each expected result goes into a scoreboard queue as the stimulus is
// driven. A second instance uses MAX_HOLD=0 and IDXW=4 to cover unlimited
// hold and the zero-filled upper index bit. Hand-written sequences cover
// asynchronous reset in the middle of a grant.
module tb_prio_arbiter;

    typedef struct {
        logic [7:0] req;
        logic       rr;
        logic [7:0] expGnt;
        logic [2:0] expIdx;
    } vec_t;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        int         tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_en;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       idle;

    logic [7:0] req0;
    logic [7:0] gnt0;
    logic [3:0] gntIdx0;
    logic       gntVld0;
    logic       idle0;

    vec_t vecs[$];
    exp_t expQ[$];
    int   errors;
    int   checks;

    prio_arbiter #(.N(8), .IDXW(3), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rr_en   (rr_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .idle    (idle)
    );

    prio_arbiter #(.N(8), .IDXW(4), .MAX_HOLD(0)) dutNoLimit (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req0),
        .rr_en   (1'b0),
        .gnt     (gnt0),
        .gnt_idx (gntIdx0),
        .gnt_vld (gntVld0),
        .idle    (idle0)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so that a broken run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input logic [7:0] r, input logic rr, input logic [7:0] g, input logic [2:0] i);
        vec_t v;
        v.req    = r;
        v.rr     = rr;
        v.expGnt = g;
        v.expIdx = i;
        vecs.push_back(v);
    endtask

    // One comparison of the main instance outputs against the expected owner.
    task automatic compareMain(input string name, input logic [7:0] eg, input logic [2:0] ei);
        logic ev;
        ev = |eg;
        checks++;
        if (gnt !== eg || gnt_idx !== ei || gnt_vld !== ev || idle !== !ev) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%h idx=%0d vld=%b idle=%b, want gnt=%h idx=%0d vld=%b idle=%b",
                     name, gnt, gnt_idx, gnt_vld, idle, eg, ei, ev, !ev);
        end
    endtask

    // Drive a vector at the falling edge, queue its expectation, then compare
    // just after the next rising edge.
    task automatic applyStimulus(input vec_t v, input int tag);
        exp_t e;
        @(negedge clk);
        req      = v.req;
        rr_en    = v.rr;
        e.gnt    = v.expGnt;
        e.idx    = v.expIdx;
        e.tag    = tag;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: output with no queued expectation");
        end else begin
            e = expQ.pop_front();
            compareMain($sformatf("vec%0d", e.tag), e.gnt, e.idx);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        req0   = 8'h00;
        rr_en  = 1'b0;

        // Idle, then a single requester on the lowest channel.
        for (int j = 0; j < 5; j++) addVec(8'h00, 1'b0, 8'h00, 3'd0);
        addVec(8'h01, 1'b0, 8'h01, 3'd0);
        addVec(8'h00, 1'b0, 8'h00, 3'd0);
        // Fixed priority: 5 wins over 2 and 0, holds, then hands to 2 on release.
        for (int j = 0; j < 4; j++) addVec(8'h25, 1'b0, 8'h20, 3'd5);
        addVec(8'h05, 1'b0, 8'h04, 3'd2);
        addVec(8'h00, 1'b0, 8'h00, 3'd0);
        // Owner 6 releases on the same edge that channel 1 arrives: no bubble.
        addVec(8'h40, 1'b0, 8'h40, 3'd6);
        addVec(8'h02, 1'b0, 8'h02, 3'd1);
        addVec(8'h00, 1'b0, 8'h00, 3'd0);
        // Hold limit of 4: channels 7 and 3 alternate in blocks of four.
        for (int j = 0; j < 4; j++) addVec(8'h88, 1'b0, 8'h80, 3'd7);
        for (int j = 0; j < 4; j++) addVec(8'h88, 1'b0, 8'h08, 3'd3);
        for (int j = 0; j < 4; j++) addVec(8'h88, 1'b0, 8'h80, 3'd7);
        addVec(8'h88, 1'b0, 8'h08, 3'd3);
        // Only channel 7 remains: it keeps the grant through the limit.
        for (int j = 0; j < 9; j++) addVec(8'h80, 1'b0, 8'h80, 3'd7);
        addVec(8'h00, 1'b0, 8'h00, 3'd0);
        // Round-robin with every channel requesting. Each owner drops for one
        // cycle, which gives the order 0..7 and then 0 again.
        addVec(8'hFF, 1'b1, 8'h01, 3'd0);
        for (int j = 1; j < 8; j++) addVec(8'hFF ^ (8'h01 << (j - 1)), 1'b1, 8'h01 << j, 3'(j));
        addVec(8'h7F, 1'b1, 8'h01, 3'd0);
        addVec(8'h00, 1'b0, 8'h00, 3'd0);

        #1;
        compareMain("resetInitial", 8'h00, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset while channel 7 owns the grant.
        begin
            vec_t v;
            v.req = 8'h80; v.rr = 1'b0; v.expGnt = 8'h80; v.expIdx = 3'd7;
            applyStimulus(v, 1000);
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            compareMain("resetAsync", 8'h00, 3'd0);
            @(posedge clk);
            #1;
            compareMain("resetHeld", 8'h00, 3'd0);
            @(negedge clk);
            rst_n = 1'b1;
            begin
                exp_t e;
                e.gnt = 8'h80; e.idx = 3'd7; e.tag = 1001;
                expQ.push_back(e);
            end
            @(posedge clk);
            #1;
            checkOutput();
        end

        // Unlimited hold with channel 3 waiting: channel 7 never loses the grant.
        @(negedge clk);
        req  = 8'h00;
        req0 = 8'h88;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (gnt0 !== 8'h80 || gntIdx0 !== 4'd7 || gntVld0 !== 1'b1 || idle0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL noLimit%0d: got gnt=%h idx=%0d vld=%b idle=%b, want gnt=80 idx=7 vld=1 idle=0",
                         j, gnt0, gntIdx0, gntVld0, idle0);
            end
        end
        @(negedge clk);
        req0 = 8'h00;
        @(posedge clk);
        #1;
        checks++;
        if (gnt0 !== 8'h00 || gntIdx0 !== 4'd0 || idle0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL noLimitRelease: got gnt=%h idx=%0d idle=%b, want gnt=00 idx=0 idle=1",
                     gnt0, gntIdx0, idle0);
        end

        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: %0d expectations never compared", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
Name: prio_arbiter

Overview:
- Parametrised, registered N-channel arbiter. Successor to the 8-input combinational priority circuit.
- Selects one requester per arbitration, issues a one-hot grant and an encoded index, and holds the grant until the owner releases its request.
- Adds a runtime round-robin mode and an optional hold-limit preemption.
- Sits between N bus masters (or shared-resource clients) and the shared resource mux.

Parameters:
- N, 8, number of request channels (N >= 2).
- IDXW, 3, width of the encoded grant index; must be at least ceil(log2(N)).
- MAX_HOLD, 0, maximum consecutive grant cycles per owner when others are waiting. 0 means unlimited (no preemption).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request lines; bit k is channel k. Level-sensitive, held high while the channel wants or uses the resource.
- rr_en  input  1  0 = fixed priority, 1 = round-robin. Sampled only at arbitration decisions.
- gnt  output  N  one-hot registered grant; all zero when there is no owner.
- gnt_idx  output  IDXW  binary index of the owner; 0 when there is no owner.
- gnt_vld  output  1  high when a grant is held (equals OR of gnt).
- idle  output  1  high when there is no owner (equals not gnt_vld).

Behaviour:
- Reset (asynchronous, immediate, also mid-grant):
  - gnt=0, gnt_idx=0, gnt_vld=0, idle=1.
  - state=IDLE, last=N-1, hold_cnt=0.
- States: IDLE, GRANT. All outputs registered.
- Latency: a request sampled at edge t produces a grant visible after edge t. No combinational path from req to gnt.
- Winner selection, over candidate set C = req with an optional owner mask:
  - Fixed mode (rr_en=0): highest set index in C wins (channel N-1 highest, channel 0 lowest).
  - RR mode (rr_en=1): first set bit searching upward from last+1, wrapping N-1 -> 0.
  - last is updated to the winner index on every new grant, in both modes.
- IDLE:
  - If req == 0: stay in IDLE; outputs unchanged.
  - Else: C = req. Grant the winner, go to GRANT, hold_cnt=0.
- GRANT, owner o:
  - Release (req[o]=0):
    - If other requests exist: grant the new winner at the same edge (no idle bubble), hold_cnt=0.
    - Else: go to IDLE and clear gnt.
  - Hold (req[o]=1, and MAX_HOLD=0 or hold_cnt < MAX_HOLD-1): keep the grant; hold_cnt increments, saturating at MAX_HOLD-1.
  - Preempt (req[o]=1, MAX_HOLD>0, hold_cnt == MAX_HOLD-1):
    - If any req[k]=1 with k != o: C = req with bit o masked; grant the winner; hold_cnt=0.
    - Else: o keeps the grant and hold_cnt resets to 0.
- Simultaneous owner release and new requests at the same edge: the new requests compete normally. The released channel is excluded automatically because its req is 0.
- A change of rr_en while in GRANT does not disturb the current owner; it takes effect at the next decision.
- Requests that are asserted and dropped while another channel owns the grant are never granted. No request latching.
- The gnt_idx width rule allows IDXW greater than ceil(log2(N)); upper bits are 0.

Test Plan:
- Reset: N=8, fixed mode, req=8'h80 granted. Pulse rst_n low mid-cycle -> gnt=0, gnt_idx=0, gnt_vld=0, idle=1 immediately (before the next clk edge). After release, req still 8'h80 -> gnt=8'h80 one edge later.
- Fixed priority: rr_en=0, req=8'b0010_0101 -> next edge gnt=8'b0010_0000, gnt_idx=5. Hold req[5] for 3 cycles -> grant unchanged. Drop req[5] -> next edge gnt=8'b0000_0100, gnt_idx=2, idle stays 0.
- Round-robin: rr_en=1, all 8 channels request. Each owner drops req for 1 cycle upon grant, then reasserts -> grant sequence 0,1,2,...,7,0. Never two consecutive grants to the same channel.
- Preemption: MAX_HOLD=4, rr_en=0, req=8'b1000_1000 held constant -> gnt_idx=7 for 4 cycles, 3 for 4 cycles, 7 for 4 cycles (alternating). With req=8'h80 only -> channel 7 holds indefinitely.
- Idle / single: req=0 for 5 cycles -> idle=1, gnt=0. Assert req=8'h01 -> next edge gnt=8'h01, gnt_idx=0, gnt_vld=1. Deassert -> next edge idle=1.
- Simultaneous: owner 6 drops req[6] on the same edge that req[1] rises (rr_en=0, no other requests) -> next edge gnt=8'h02, gnt_idx=1, with no idle cycle in between.
